// File: rtl/core_pkg.sv
// Shared integer-core constants: register file geometry and pending-counter type.
// Ports: none (package).
// Consumers import core_pkg::* and use these as parameter defaults.
package core_pkg;
  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int AW       = $clog2(NREGS);
  localparam int PEND_W   = 2;
  localparam int REG_ZERO = 0;

  typedef logic [PEND_W-1:0] pend_t;
endpackage

// File: rtl/rf_pend_counter.sv
// Per-register pending-write counter: counts issued-but-not-written-back writes.
// Ports: clk/rst, inc (issue claims reg), dec (writeback to reg), flush (drop all claims),
//        count, full (no more claims allowed), nonzero (a write is still in flight).
module rf_pend_counter
  import core_pkg::*;
#(
  parameter int CNT_W = core_pkg::PEND_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             nonzero
);

  logic dec_ok;
  logic inc_ok;

  assign nonzero = (count != '0);
  assign full    = &count;

  // A writeback with no claim outstanding is a late writeback after flush;
  // it must not pull the counter below zero.
  assign dec_ok = dec & nonzero;
  // Issue already stalls on a full counter; the guard only keeps the
  // counter from wrapping if that contract is ever broken.
  assign inc_ok = inc & (~full | dec_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (inc_ok && !dec_ok) begin
      count <= count + CNT_W'(1);
    end else if (dec_ok && !inc) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-to-read bypass, debug read port and
// per-register pending-write scoreboard that produces the decode stall.
// Ports: rs1/rs2 read (comb, bypassed), issue side (valid/use/rd -> stall),
//        writeback side (valid/addr/data), flush, debug read (comb, no bypass).
module regfile_scoreboard
  import core_pkg::*;
#(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int NREGS  = core_pkg::NREGS,
  parameter int PEND_W = core_pkg::PEND_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  input  logic            issue_rd_we,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_stall,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0]              regs [NREGS];
  logic [NREGS-1:0][PEND_W-1:0] pend;
  logic [NREGS-1:0]             pend_full;
  logic [NREGS-1:0]             pend_nz;

  logic wb_hit1, wb_hit2, wb_hit_rd;
  logic haz1, haz2, cap;
  logic issue_accept;

  // ---------------------------------------------------------------
  // Storage: x0 is never written, so it stays at its reset value 0.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid && (wb_addr != ZERO_ADDR)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // ---------------------------------------------------------------
  // Reads. The bypass is suppressed during reset so every port reads 0.
  // ---------------------------------------------------------------
  assign wb_hit1   = wb_valid && (wb_addr == rs1_addr);
  assign wb_hit2   = wb_valid && (wb_addr == rs2_addr);
  assign wb_hit_rd = wb_valid && (wb_addr == issue_rd);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    dbg_data = '0;
    if (!rst) begin
      if (rs1_addr != ZERO_ADDR) begin
        rs1_data = wb_hit1 ? wb_data : regs[rs1_addr];
      end
      if (rs2_addr != ZERO_ADDR) begin
        rs2_data = wb_hit2 ? wb_data : regs[rs2_addr];
      end
      dbg_data = regs[dbg_addr];
    end
  end

  // ---------------------------------------------------------------
  // Scoreboard. x0 has no counter: it can never be a hazard or fill up.
  // ---------------------------------------------------------------
  assign pend[0]      = '0;
  assign pend_full[0] = 1'b0;
  assign pend_nz[0]   = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_pend
    rf_pend_counter #(
      .CNT_W (PEND_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (issue_accept && issue_rd_we && (issue_rd == AW'(g))),
      .dec     (wb_valid && (wb_addr == AW'(g))),
      .flush   (flush),
      .count   (pend[g]),
      .full    (pend_full[g]),
      .nonzero (pend_nz[g])
    );
  end

  // The last outstanding write landing this cycle releases the hazard;
  // the bypass path delivers its data to the reader in the same cycle.
  assign haz1 = issue_use_rs1 && pend_nz[rs1_addr] &&
                !((pend[rs1_addr] == PEND_W'(1)) && wb_hit1);
  assign haz2 = issue_use_rs2 && pend_nz[rs2_addr] &&
                !((pend[rs2_addr] == PEND_W'(1)) && wb_hit2);

  // A full counter can take one more claim only if a writeback frees a slot
  // in the same cycle (full implies nonzero, so that writeback decrements).
  assign cap = issue_rd_we && pend_full[issue_rd] && !wb_hit_rd;

  assign issue_stall  = !rst && issue_valid && !flush && (haz1 || haz2 || cap);
  assign issue_accept = !rst && issue_valid && !flush && !issue_stall;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int XL   = 32;
  localparam int NR   = 32;
  localparam int A    = 5;
  localparam int PMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [A-1:0]  rs1_addr, rs2_addr, issue_rd, wb_addr, dbg_addr;
  logic [XL-1:0] rs1_data, rs2_data, wb_data, dbg_data;
  logic          issue_valid, issue_use_rs1, issue_use_rs2, issue_rd_we;
  logic          issue_stall, wb_valid, flush;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural values and outstanding-write counts.
  logic [XL-1:0] mregs [NR];
  int            mpend [NR];

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2), .issue_rd_we(issue_rd_we),
    .issue_rd(issue_rd), .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [XL-1:0] exp_read(input logic [A-1:0] a);
    if (rst || a == 0) return '0;
    if (wb_valid && wb_addr == a) return wb_data;
    return mregs[a];
  endfunction

  function automatic bit exp_stall();
    bit h1, h2, c;
    if (rst || !issue_valid || flush) return 1'b0;
    h1 = issue_use_rs1 && rs1_addr != 0 && mpend[rs1_addr] > 0 &&
         !(mpend[rs1_addr] == 1 && wb_valid && wb_addr == rs1_addr);
    h2 = issue_use_rs2 && rs2_addr != 0 && mpend[rs2_addr] > 0 &&
         !(mpend[rs2_addr] == 1 && wb_valid && wb_addr == rs2_addr);
    c  = issue_rd_we && issue_rd != 0 && mpend[issue_rd] == PMAX &&
         !(wb_valid && wb_addr == issue_rd);
    return h1 || h2 || c;
  endfunction

  // Model state update at each clock edge, from the inputs held across it.
  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        mregs[r] = '0;
        mpend[r] = 0;
      end
    end else begin
      acc = issue_valid && !flush && !exp_stall();
      for (int r = 1; r < NR; r++) begin
        int d;
        d = 0;
        if (acc && issue_rd_we && issue_rd == r) d = d + 1;
        if (wb_valid && wb_addr == r && mpend[r] > 0) d = d - 1;
        mpend[r] = flush ? 0 : mpend[r] + d;
      end
      if (wb_valid && wb_addr != 0) mregs[wb_addr] = wb_data;
    end
  end

  task automatic cmp(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    cmp("rs1_data",    rs1_data, exp_read(rs1_addr));
    cmp("rs2_data",    rs2_data, exp_read(rs2_addr));
    cmp("dbg_data",    dbg_data, rst ? '0 : mregs[dbg_addr]);
    cmp("issue_stall", {31'd0, issue_stall}, {31'd0, exp_stall()});
  end

  task automatic idle();
    rs1_addr = 0; rs2_addr = 0; issue_rd = 0; wb_addr = 0; dbg_addr = 0;
    wb_data = 0; issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0;
    issue_rd_we = 0; wb_valid = 0; flush = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic issue_wr(input logic [A-1:0] rd);
    idle(); issue_valid = 1; issue_rd_we = 1; issue_rd = rd;
  endtask

  task automatic reader1(input logic [A-1:0] a);
    idle(); issue_valid = 1; issue_use_rs1 = 1; rs1_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // During reset the bypass is silent and issue never stalls.
    issue_valid = 1; issue_use_rs1 = 1; rs1_addr = 5;
    wb_valid = 1; wb_addr = 5; wb_data = 32'hCAFE_F00D;
    @(negedge clk);
    cmp("lit_rst_rs1", rs1_data, 32'h0);
    cmp("lit_rst_stall", {31'd0, issue_stall}, 32'h0);
    next(); next();
    rst = 1'b0;

    // Write reg5, read it back, then reset mid-run.
    idle(); wb_valid = 1; wb_addr = 5; wb_data = 32'hDEAD_BEEF;
    next();
    idle(); dbg_addr = 5;
    @(negedge clk); cmp("lit_dbg5", dbg_data, 32'hDEAD_BEEF);
    next();
    idle(); dbg_addr = 5; rst = 1'b1;
    #1 cmp("lit_async_rst_dbg5", dbg_data, 32'h0);
    next();
    rst = 1'b0;
    idle(); dbg_addr = 5;
    @(negedge clk); cmp("lit_after_rst_dbg5", dbg_data, 32'h0);
    next();

    // x0: writes dropped, never a hazard.
    idle(); wb_valid = 1; wb_addr = 0; wb_data = 32'h1234; rs1_addr = 0;
    @(negedge clk); cmp("lit_x0_bypass", rs1_data, 32'h0);
    next();
    issue_wr(0);
    next();
    reader1(0); dbg_addr = 0;
    @(negedge clk);
    cmp("lit_x0_stall", {31'd0, issue_stall}, 32'h0);
    cmp("lit_x0_dbg", dbg_data, 32'h0);
    next();

    // RAW hazard on x3 released by its writeback with bypass.
    issue_wr(3);
    @(negedge clk); cmp("lit_issue3_stall", {31'd0, issue_stall}, 32'h0);
    next();
    reader1(3);
    @(negedge clk); cmp("lit_raw_t1", {31'd0, issue_stall}, 32'h1);
    next();
    @(negedge clk); cmp("lit_raw_t2", {31'd0, issue_stall}, 32'h1);
    next();
    wb_valid = 1; wb_addr = 3; wb_data = 32'h55;
    @(negedge clk);
    cmp("lit_raw_release", {31'd0, issue_stall}, 32'h0);
    cmp("lit_raw_bypass", rs1_data, 32'h55);
    next();

    // Three writes in flight to x7 fill the counter.
    for (int i = 0; i < 3; i++) begin
      issue_wr(7);
      @(negedge clk); cmp("lit_fill7", {31'd0, issue_stall}, 32'h0);
      next();
    end
    issue_wr(7);
    @(negedge clk); cmp("lit_cap7", {31'd0, issue_stall}, 32'h1);
    wb_valid = 1; wb_addr = 7; wb_data = 32'h77;
    #1 cmp("lit_cap7_with_wb", {31'd0, issue_stall}, 32'h0);
    next();
    issue_wr(7);
    @(negedge clk); cmp("lit_cap7_still_full", {31'd0, issue_stall}, 32'h1);
    next();

    // Flush discards claims; a late writeback still lands.
    issue_wr(9); next();
    issue_wr(9); next();
    reader1(9);
    @(negedge clk); cmp("lit_pend9", {31'd0, issue_stall}, 32'h1);
    flush = 1;
    #1 cmp("lit_flush_nostall", {31'd0, issue_stall}, 32'h0);
    next();
    reader1(9);
    @(negedge clk); cmp("lit_after_flush9", {31'd0, issue_stall}, 32'h0);
    next();
    idle(); wb_valid = 1; wb_addr = 9; wb_data = 32'hAA;
    next();
    reader1(9); dbg_addr = 9;
    @(negedge clk);
    cmp("lit_late_wb9", dbg_data, 32'hAA);
    cmp("lit_late_wb9_stall", {31'd0, issue_stall}, 32'h0);
    next();

    // Random traffic, mostly on a few registers to provoke hazards.
    for (int n = 0; n < 4000; n++) begin
      bit narrow;
      narrow        = ($urandom_range(0, 3) != 0);
      issue_valid   = $urandom_range(0, 1);
      issue_use_rs1 = $urandom_range(0, 1);
      issue_use_rs2 = $urandom_range(0, 1);
      issue_rd_we   = $urandom_range(0, 1);
      rs1_addr      = narrow ? A'($urandom_range(0, 7)) : A'($urandom);
      rs2_addr      = narrow ? A'($urandom_range(0, 7)) : A'($urandom);
      issue_rd      = narrow ? A'($urandom_range(0, 7)) : A'($urandom);
      wb_valid      = $urandom_range(0, 1);
      wb_addr       = narrow ? A'($urandom_range(0, 7)) : A'($urandom);
      wb_data       = $urandom;
      flush         = ($urandom_range(0, 40) == 0);
      dbg_addr      = A'($urandom);
      rst           = ($urandom_range(0, 999) == 0);
      next();
    end
    rst = 0;
    idle();
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
